pat_timing_gen: RTL and testbench
=================================

PAT_TIMING_GEN -- requirements
Module: pat_timing_gen

Interface
REQ-001 SHALL have parameter H_SYNC, default 2: hsync width in clocks.
REQ-002 SHALL have parameter H_BP, default 3: clocks from hsync end to de start.
REQ-003 SHALL have parameter H_ACTIVE, default 82: de clocks per line (80 pixels plus 2 DMD pad).
REQ-004 SHALL have parameter H_FP, default 5: clocks from de end to line end.
REQ-005 SHALL have parameters V_SYNC/V_BP/V_ACTIVE/V_FP, defaults 2/3/1080/2: lines per vertical region.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-008 SHALL have port frame_trig, input, 1: start one frame; level sampled in IDLE.
REQ-009 SHALL have port frame_busy, output, 1: frame in progress.
REQ-010 SHALL have port frame_done, output, 1: one-clock pulse at frame end.
REQ-011 SHALL have port trig_dropped, output, 1: one-clock pulse when frame_trig is ignored.
REQ-012 SHALL have ports h_sync, v_sync and de, output, 1 each: active-high timing to the pattern fetch stage.

Function
REQ-013 Line = H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP clocks.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0.
- v line counter advances on the wrap.
REQ-014 States: IDLE, VSYNC, VBP, ACTIVE, VFP.
- IDLE->VSYNC when frame_trig=1.
- VSYNC->VBP after V_SYNC lines; VBP->ACTIVE after V_BP lines; ACTIVE->VFP after V_ACTIVE lines; VFP->IDLE after V_FP lines.
REQ-015 frame_trig sampled high in IDLE at edge N -> frame_busy=1, v_sync=1, h_cnt=0 at edge N+1.
REQ-016 v_sync=1 for every clock of VSYNC lines; 0 elsewhere.
REQ-017 h_sync=1 for h_cnt 0..H_SYNC-1 on ACTIVE lines only; 0 on all other lines, so the downstream line count equals V_ACTIVE at the last active line.
REQ-018 de=1 for h_cnt H_SYNC+H_BP .. H_SYNC+H_BP+H_ACTIVE-1 on ACTIVE lines only.
REQ-019 All outputs SHALL be registered, with no combinational input-to-output path.
REQ-020 Frame end:
- last VFP clock (h_cnt=H_TOTAL-1, last VFP line) -> next edge: frame_busy=0, frame_done=1 for one clock, state IDLE.
REQ-021 IDLE SHALL last at least one clock; frame_trig held high gives back-to-back frames separated by exactly one IDLE clock.
REQ-022 frame_trig=1 while state != IDLE SHALL NOT restart, extend or alter the frame; trig_dropped=1 the next clock.
REQ-023 Counters SHALL be 12 bits; every parameter SHALL satisfy 1 <= value <= 4095 and H_TOTAL <= 4095, checked at elaboration.
REQ-024 Frame length SHALL be exactly (V_SYNC+V_BP+V_ACTIVE+V_FP)*H_TOTAL clocks from frame_busy rise to fall.

Reset
REQ-025 rst_n=0 at any edge, including mid-frame, SHALL give at the next edge:
- state IDLE, counters 0;
- h_sync, v_sync, de, frame_busy, frame_done, trig_dropped all 0.
REQ-026 The first frame_trig after reset release SHALL be honoured per REQ-015.

Structure
REQ-027 Package pat_timing_pkg SHALL hold:
- the state enumeration;
- default timing constants (82 de clocks, 1080 active lines);
- the 12-bit counter width constant.
REQ-028 One sub-module, pat_hv_counter (h_cnt with wrap and line counter with region-end flags), SHALL be instantiated once.

Verification (small profile: H 2/3/82/5, H_TOTAL=92; V 2/3/4/2)
REQ-029 Single pulse: trig pulse at clock 10:
- v_sync high clocks 11..194;
- first h_sync clocks 471..472;
- first de clocks 476..557;
- frame_done at clock 1023;
- frame_busy high exactly 1012 clocks.
REQ-030 Line count: one frame -> exactly 4 h_sync rising edges and 4*82=328 de clocks; no h_sync during VSYNC/VBP/VFP.
REQ-031 Held trigger: frame_trig held high for 2 frames -> frame_busy low for exactly one clock between frames; second v_sync rise 1013 clocks after first.
REQ-032 Busy trigger: trig pulse at clock 300 of a frame -> trig_dropped=1 at 301; frame timing identical to REQ-029.
REQ-033 Mid-frame reset: rst_n=0 for one clock during de -> all outputs 0 next clock; new trig produces a full frame matching REQ-029 offsets.
REQ-034 Default profile: one frame -> 1080 h_sync rises; last de falling edge occurs with the downstream line count = 1080.

Source files
------------

// File: rtl/pat_timing_pkg.sv
// rtl/pat_timing_pkg.sv - shared states, counter width and default timing for the pattern timing generator
package pat_timing_pkg;

  localparam int CNT_W        = 12;
  localparam int DEF_H_ACTIVE = 82;
  localparam int DEF_V_ACTIVE = 1080;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBP,
    ST_ACTIVE,
    ST_VFP
  } state_t;

endpackage

// File: rtl/pat_hv_counter.sv
// rtl/pat_hv_counter.sv - pixel counter with line wrap and per-region line counter
module pat_hv_counter
  import pat_timing_pkg::*;
#(
  parameter int H_TOTAL = 92
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [CNT_W-1:0] region_last,
  output logic [CNT_W-1:0] h_nxt,
  output logic             line_end,
  output logic             region_end
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] v_nxt;

  assign line_end   = (h_cnt == H_LAST);
  assign region_end = line_end && (v_cnt == region_last);

  // Both counters sit at zero while idle so a new frame always starts at pixel 0, line 0.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (run) begin
      h_nxt = line_end ? '0 : h_cnt + 1'b1;
      if (region_end) begin
        v_nxt = '0;
      end else if (line_end) begin
        v_nxt = v_cnt + 1'b1;
      end else begin
        v_nxt = v_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

endmodule

// File: rtl/pat_timing_gen.sv
// rtl/pat_timing_gen.sv - triggered single-frame h_sync/v_sync/de generator for the pattern fetch stage
module pat_timing_gen
  import pat_timing_pkg::*;
#(
  parameter int H_SYNC   = 2,
  parameter int H_BP     = 3,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = 5,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 3,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_trig,
  output logic frame_busy,
  output logic frame_done,
  output logic trig_dropped,
  output logic h_sync,
  output logic v_sync,
  output logic de
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;

  if (H_SYNC < 1 || H_SYNC > 4095 || H_BP < 1 || H_BP > 4095 ||
      H_ACTIVE < 1 || H_ACTIVE > 4095 || H_FP < 1 || H_FP > 4095 ||
      V_SYNC < 1 || V_SYNC > 4095 || V_BP < 1 || V_BP > 4095 ||
      V_ACTIVE < 1 || V_ACTIVE > 4095 || V_FP < 1 || V_FP > 4095 ||
      H_TOTAL > 4095) begin : g_param_check
    $error("pat_timing_gen: timing parameter out of range");
  end

  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] DE_BEG = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] DE_END = CNT_W'(H_SYNC + H_BP + H_ACTIVE);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] region_last;
  logic [CNT_W-1:0] h_nxt;
  logic             line_end;
  logic             region_end;

  pat_hv_counter #(
    .H_TOTAL(H_TOTAL)
  ) u_hv_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (state != ST_IDLE),
    .region_last(region_last),
    .h_nxt      (h_nxt),
    .line_end   (line_end),
    .region_end (region_end)
  );

  always_comb begin
    region_last = CNT_W'(V_FP - 1);
    case (state)
      ST_VSYNC:  region_last = CNT_W'(V_SYNC - 1);
      ST_VBP:    region_last = CNT_W'(V_BP - 1);
      ST_ACTIVE: region_last = CNT_W'(V_ACTIVE - 1);
      default:   region_last = CNT_W'(V_FP - 1);
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (frame_trig) state_nxt = ST_VSYNC;
      ST_VSYNC:  if (region_end) state_nxt = ST_VBP;
      ST_VBP:    if (region_end) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (region_end) state_nxt = ST_VFP;
      ST_VFP:    if (region_end) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are decoded from the next state and next pixel so they line up with the counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_busy   <= 1'b0;
      frame_done   <= 1'b0;
      trig_dropped <= 1'b0;
      h_sync       <= 1'b0;
      v_sync       <= 1'b0;
      de           <= 1'b0;
    end else begin
      frame_busy   <= (state_nxt != ST_IDLE);
      frame_done   <= (state == ST_VFP) && region_end;
      trig_dropped <= (state != ST_IDLE) && frame_trig;
      v_sync       <= (state_nxt == ST_VSYNC);
      h_sync       <= (state_nxt == ST_ACTIVE) && (h_nxt < HS_END);
      de           <= (state_nxt == ST_ACTIVE) && (h_nxt >= DE_BEG) && (h_nxt < DE_END);
    end
  end

endmodule

// File: tb/tb_pat_timing_gen.sv
// tb/tb_pat_timing_gen.sv - checks frame timing against an arithmetic per-clock reference
module tb_pat_timing_gen;

  localparam int HS = 2, HB = 3, HA = 82, HF = 5;
  localparam int HT = HS + HB + HA + HF;
  localparam int VS = 2, VB = 3, VA = 4, VF = 2;
  localparam int FL = (VS + VB + VA + VF) * HT;
  localparam int D2_FL = (2 + 3 + 1080 + 2) * 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_trig = 1'b0;
  logic trig2 = 1'b0;
  logic frame_busy, frame_done, trig_dropped, h_sync, v_sync, de;
  logic busy2, done2, drop2, hs2, vs2, de2;

  always #5 clk = ~clk;

  pat_timing_gen #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_FP(HF),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_FP(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_trig(frame_trig),
    .frame_busy(frame_busy), .frame_done(frame_done), .trig_dropped(trig_dropped),
    .h_sync(h_sync), .v_sync(v_sync), .de(de)
  );

  pat_timing_gen #(
    .H_SYNC(1), .H_BP(1), .H_ACTIVE(1), .H_FP(1)
  ) dut_tall (
    .clk(clk), .rst_n(rst_n), .frame_trig(trig2),
    .frame_busy(busy2), .frame_done(done2), .trig_dropped(drop2),
    .h_sync(hs2), .v_sync(vs2), .de(de2)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fs = -1;
  logic exp_drop = 1'b0;

  int busy_cnt, hs_rises, de_cnt, done_cyc, drop_cyc, vs_rises, first_vs, second_vs;
  int first_hs, first_de, low_between;
  int hs2_rises, vs2_rises, busy2_cnt, done2_cnt, drop2_cnt, fall_lines;
  logic p_hs = 1'b0, p_vs = 1'b0, p_de = 1'b0, p_hs2 = 1'b0, p_vs2 = 1'b0, p_de2 = 1'b0;

  function automatic logic in_frame(int c);
    return (fs >= 0) && (c >= fs) && (c < fs + FL);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0b expected %0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    busy_cnt = 0; hs_rises = 0; de_cnt = 0; done_cyc = -1; drop_cyc = -1;
    vs_rises = 0; first_vs = -1; second_vs = -1; first_hs = -1; first_de = -1;
    low_between = 0;
    hs2_rises = 0; vs2_rises = 0; busy2_cnt = 0; done2_cnt = 0; drop2_cnt = 0; fall_lines = -1;
  endtask

  task automatic check_model();
    int off, line, h;
    logic f, act;
    off  = cyc - fs;
    f    = in_frame(cyc);
    line = f ? off / HT : 0;
    h    = f ? off % HT : 0;
    act  = f && (line >= VS + VB) && (line < VS + VB + VA);
    chk("frame_busy", frame_busy, f);
    chk("v_sync", v_sync, f && (line < VS));
    chk("h_sync", h_sync, act && (h < HS));
    chk("de", de, act && (h >= HS + HB) && (h < HS + HB + HA));
    chk("frame_done", frame_done, (fs >= 0) && (off == FL));
    chk("trig_dropped", trig_dropped, exp_drop);
  endtask

  task automatic tick(input logic t, input logic r, input logic t2);
    frame_trig = t;
    rst_n      = r;
    trig2      = t2;
    if (!r) begin
      fs = -1;
      exp_drop = 1'b0;
    end else if (t) begin
      if (in_frame(cyc)) begin
        exp_drop = 1'b1;
      end else begin
        fs = cyc + 1;
        exp_drop = 1'b0;
      end
    end else begin
      exp_drop = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_model();
    if (frame_busy) busy_cnt++;
    if (de) de_cnt++;
    if (frame_done) done_cyc = cyc;
    if (trig_dropped && drop_cyc < 0) drop_cyc = cyc;
    if (h_sync && !p_hs) begin
      hs_rises++;
      if (first_hs < 0) first_hs = cyc;
    end
    if (de && !p_de && first_de < 0) first_de = cyc;
    if (v_sync && !p_vs) begin
      vs_rises++;
      if (vs_rises == 1) first_vs = cyc;
      if (vs_rises == 2) second_vs = cyc;
    end
    if (vs_rises == 1 && !frame_busy) low_between++;
    if (busy2) busy2_cnt++;
    if (done2) done2_cnt++;
    if (drop2) drop2_cnt++;
    if (hs2 && !p_hs2) hs2_rises++;
    if (vs2 && !p_vs2) vs2_rises++;
    if (!de2 && p_de2) fall_lines = hs2_rises;
    p_hs = h_sync; p_vs = v_sync; p_de = de;
    p_hs2 = hs2; p_vs2 = vs2; p_de2 = de2;
  endtask

  initial begin
    int t0;
    clear_stats();

    // reset state
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);

    // single pulse
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0);
    clear_stats();
    t0 = cyc;
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < FL + 15; i++) tick(1'b0, 1'b1, 1'b0);
    chk_int("single_vs_rise", first_vs - t0, 1);
    chk_int("single_hs_first", first_hs - t0, 461);
    chk_int("single_de_first", first_de - t0, 466);
    chk_int("single_done", done_cyc - t0, FL + 1);
    chk_int("single_busy_len", busy_cnt, FL);
    chk_int("single_hs_rises", hs_rises, VA);
    chk_int("single_de_clocks", de_cnt, VA * HA);

    // trigger while busy
    clear_stats();
    t0 = cyc;
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < FL + 15; i++) tick(i == 300, 1'b1, 1'b0);
    chk_int("busy_trig_drop", drop_cyc - t0, 301);
    chk_int("busy_trig_done", done_cyc - t0, FL + 1);
    chk_int("busy_trig_len", busy_cnt, FL);

    // held trigger, back-to-back frames
    clear_stats();
    t0 = cyc;
    for (int i = 0; i < FL + 4; i++) tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < FL + 10; i++) tick(1'b0, 1'b1, 1'b0);
    chk_int("held_vs_gap", second_vs - first_vs, FL + 1);
    chk_int("held_idle_clocks", low_between, 1);
    chk_int("held_busy_total", busy_cnt, 2 * FL);

    // reset during de
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 1000 && !de; i++) tick(1'b0, 1'b1, 1'b0);
    chk("wait_de", de, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    chk("rst_outputs_zero", frame_busy | frame_done | trig_dropped | h_sync | v_sync | de, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);
    clear_stats();
    t0 = cyc;
    tick(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < FL + 10; i++) tick(1'b0, 1'b1, 1'b0);
    chk_int("post_rst_hs_first", first_hs - t0, 461);
    chk_int("post_rst_done", done_cyc - t0, FL + 1);
    chk_int("post_rst_busy_len", busy_cnt, FL);

    // random triggers and resets against the reference
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 99) < 3, $urandom_range(0, 999) != 0, 1'b0);
    end
    for (int i = 0; i < FL + 5; i++) tick(1'b0, 1'b1, 1'b0);

    // full-height frame on the default vertical profile
    clear_stats();
    tick(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < D2_FL + 10; i++) tick(1'b0, 1'b1, 1'b0);
    chk_int("tall_hs_rises", hs2_rises, 1080);
    chk_int("tall_lines_at_last_de", fall_lines, 1080);
    chk_int("tall_busy_len", busy2_cnt, D2_FL);
    chk_int("tall_done_pulses", done2_cnt, 1);
    chk_int("tall_vs_rises", vs2_rises, 1);
    chk_int("tall_no_drop", drop2_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
